// File: rtl/regfile_mp_scoreboard_if.sv
// Register-file bus: read ports, write-back lanes, issue/flush control and conflict flag.
// "master" drives addresses and write data; "slave" is the register file itself.
interface regfile_mp_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 3,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;
    logic                     flush;
    logic                     write_conflict;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        input  rd_data, rd_busy, write_conflict
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        output rd_data, rd_busy, write_conflict
    );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with fixed-priority writes (highest port wins), write-to-read
// bypass, optional hardwired zero register and a per-register busy scoreboard.
module regfile_mp_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    regfile_mp_scoreboard_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              write_conflict_q;
    logic              write_conflict_d;

    logic [NUM_WR-1:0]        wr_live;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;
    logic [ADDR_W-1:0]        ra;
    logic                     issue_live;

    // A write lane is live when enabled and not aimed at the hardwired zero register.
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            wr_live[k] = bus.wr_en[k] &&
                         !(ZR && (bus.wr_addr[k*ADDR_W +: ADDR_W] == '0));
        end
        issue_live = bus.issue_en && !(ZR && (bus.issue_addr == '0));
    end

    always_comb begin
        regs_d           = regs_q;
        busy_d           = busy_q;
        write_conflict_d = 1'b0;
        // Ascending order lets the highest-index lane overwrite lower ones.
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_live[k]) begin
                regs_d[bus.wr_addr[k*ADDR_W +: ADDR_W]] = bus.wr_data[k*DATA_W +: DATA_W];
                busy_d[bus.wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
            for (int j = 0; j < k; j++) begin
                if (wr_live[k] && wr_live[j] &&
                    (bus.wr_addr[k*ADDR_W +: ADDR_W] == bus.wr_addr[j*ADDR_W +: ADDR_W])) begin
                    write_conflict_d = 1'b1;
                end
            end
        end
        // Flush overrides everything; otherwise a new producer beats its own writeback clear.
        if (bus.flush) begin
            busy_d = '0;
        end else if (issue_live) begin
            busy_d[bus.issue_addr] = 1'b1;
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ra        = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
            rd_data_c[i*DATA_W +: DATA_W] = regs_q[ra];
            rd_busy_c[i]                  = busy_q[ra];
            if (BP) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (bus.wr_en[k] && (bus.wr_addr[k*ADDR_W +: ADDR_W] == ra)) begin
                        rd_data_c[i*DATA_W +: DATA_W] = bus.wr_data[k*DATA_W +: DATA_W];
                        rd_busy_c[i]                  = 1'b0;
                    end
                end
            end
            if (ZR && (ra == '0)) begin
                rd_data_c[i*DATA_W +: DATA_W] = '0;
                rd_busy_c[i]                  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int a = 0; a < DEPTH; a++) begin
                regs_q[a] <= '0;
            end
            busy_q           <= '0;
            write_conflict_q <= 1'b0;
        end else begin
            regs_q           <= regs_d;
            busy_q           <= busy_d;
            write_conflict_q <= write_conflict_d;
        end
    end

    assign bus.rd_data        = rd_data_c;
    assign bus.rd_busy        = rd_busy_c;
    assign bus.write_conflict = write_conflict_q;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Scoreboard bench: two DUTs (zero-reg+bypass, and neither) share stimulus; a reference
// model pushes expected outputs per cycle and a negedge monitor pops and compares.
module tb_regfile_mp_scoreboard;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 3;
    localparam int NW    = 2;
    localparam int DEPTH = 1 << AW;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    regfile_mp_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus_a ();
    regfile_mp_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus_b ();

    assign bus_b.rd_addr    = bus_a.rd_addr;
    assign bus_b.wr_en      = bus_a.wr_en;
    assign bus_b.wr_addr    = bus_a.wr_addr;
    assign bus_b.wr_data    = bus_a.wr_data;
    assign bus_b.issue_en   = bus_a.issue_en;
    assign bus_b.issue_addr = bus_a.issue_addr;
    assign bus_b.flush      = bus_a.flush;

    regfile_mp_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                            .ZERO_REG(1), .BYPASS(1)) dut_a (
        .CLK(CLK), .RESET(RESET), .bus(bus_a.slave));

    regfile_mp_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                            .ZERO_REG(0), .BYPASS(0)) dut_b (
        .CLK(CLK), .RESET(RESET), .bus(bus_b.slave));

    // Stimulus for the current cycle
    logic [AW-1:0] s_rd_addr [NR];
    logic          s_wr_en   [NW];
    logic [AW-1:0] s_wr_addr [NW];
    logic [DW-1:0] s_wr_data [NW];
    logic          s_issue_en;
    logic [AW-1:0] s_issue_addr;
    logic          s_flush;

    // Reference model: index 0 = dut_a (zero reg, bypass), 1 = dut_b (neither)
    logic [DW-1:0] m_reg  [2][DEPTH];
    bit            m_busy [2][DEPTH];
    bit            m_conf [2];
    bit            zr [2] = '{1'b1, 1'b0};
    bit            bp [2] = '{1'b1, 1'b0};

    typedef struct packed {
        int            cyc;
        logic [NR*DW-1:0] data_a;
        logic [NR*DW-1:0] data_b;
        logic [NR-1:0] busy_a;
        logic [NR-1:0] busy_b;
        logic          conf_a;
        logic          conf_b;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic idle();
        for (int i = 0; i < NR; i++) s_rd_addr[i] = '0;
        for (int k = 0; k < NW; k++) begin
            s_wr_en[k] = 1'b0; s_wr_addr[k] = '0; s_wr_data[k] = '0;
        end
        s_issue_en = 1'b0; s_issue_addr = '0; s_flush = 1'b0;
    endtask

    task automatic apply();
        for (int i = 0; i < NR; i++) bus_a.rd_addr[i*AW +: AW] = s_rd_addr[i];
        for (int k = 0; k < NW; k++) begin
            bus_a.wr_en[k]             = s_wr_en[k];
            bus_a.wr_addr[k*AW +: AW]  = s_wr_addr[k];
            bus_a.wr_data[k*DW +: DW]  = s_wr_data[k];
        end
        bus_a.issue_en   = s_issue_en;
        bus_a.issue_addr = s_issue_addr;
        bus_a.flush      = s_flush;
    endtask

    function automatic void model_read(input int d, input int i,
                                       output logic [DW-1:0] data, output logic busy);
        int hit;
        hit = -1;
        if (zr[d] && s_rd_addr[i] == 0) begin
            data = '0; busy = 1'b0;
            return;
        end
        if (bp[d]) begin
            for (int k = NW - 1; k >= 0; k--) begin
                if (s_wr_en[k] && s_wr_addr[k] == s_rd_addr[i]) begin hit = k; break; end
            end
        end
        if (hit >= 0) begin
            data = s_wr_data[hit]; busy = 1'b0;
        end else begin
            data = m_reg[d][s_rd_addr[i]]; busy = m_busy[d][s_rd_addr[i]];
        end
    endfunction

    function automatic void push_expect();
        exp_t e;
        logic [DW-1:0] dv;
        logic bv;
        e = '0;
        e.cyc = cyc;
        for (int i = 0; i < NR; i++) begin
            model_read(0, i, dv, bv); e.data_a[i*DW +: DW] = dv; e.busy_a[i] = bv;
            model_read(1, i, dv, bv); e.data_b[i*DW +: DW] = dv; e.busy_b[i] = bv;
        end
        e.conf_a = m_conf[0];
        e.conf_b = m_conf[1];
        exp_q.push_back(e);
    endfunction

    function automatic void model_commit();
        int  writers [DEPTH];
        bit  taken   [DEPTH];
        bit  eff;
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < DEPTH; a++) begin writers[a] = 0; taken[a] = 0; end
            m_conf[d] = 0;
            // Highest port first; the first port to claim an address owns its value.
            for (int k = NW - 1; k >= 0; k--) begin
                eff = s_wr_en[k] && !(zr[d] && s_wr_addr[k] == 0);
                if (eff) begin
                    writers[s_wr_addr[k]]++;
                    if (!taken[s_wr_addr[k]]) begin
                        m_reg[d][s_wr_addr[k]] = s_wr_data[k];
                        taken[s_wr_addr[k]] = 1;
                    end
                end
            end
            for (int a = 0; a < DEPTH; a++) if (writers[a] > 1) m_conf[d] = 1;
            if (s_flush) begin
                for (int a = 0; a < DEPTH; a++) m_busy[d][a] = 0;
            end else begin
                for (int a = 0; a < DEPTH; a++) if (taken[a]) m_busy[d][a] = 0;
                if (s_issue_en && !(zr[d] && s_issue_addr == 0)) m_busy[d][s_issue_addr] = 1;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < DEPTH; a++) begin m_reg[d][a] = '0; m_busy[d][a] = 0; end
            m_conf[d] = 0;
        end
    endfunction

    task automatic step();
        @(posedge CLK); #1;
        cyc++;
        apply();
        push_expect();
        model_commit();
    endtask

    // Reset is pulsed between edges with non-writing inputs and released before the next edge.
    task automatic do_reset();
        @(posedge CLK); #1;
        cyc++;
        RESET = 1'b0;
        s_issue_en = 1'b0; s_flush = 1'b0;
        for (int k = 0; k < NW; k++) s_wr_en[k] = 1'b0;
        apply();
        model_reset();
        push_expect();
        model_commit();
        @(negedge CLK); #2;
        RESET = 1'b1;
    endtask

    task automatic chk(input string nm, input int port, input int c,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] cyc=%0d actual=%h expected=%h", nm, port, c, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < NR; i++) begin
                    chk("a.rd_data", i, e.cyc, bus_a.rd_data[i*DW +: DW], e.data_a[i*DW +: DW]);
                    chk("a.rd_busy", i, e.cyc, {31'd0, bus_a.rd_busy[i]}, {31'd0, e.busy_a[i]});
                    chk("b.rd_data", i, e.cyc, bus_b.rd_data[i*DW +: DW], e.data_b[i*DW +: DW]);
                    chk("b.rd_busy", i, e.cyc, {31'd0, bus_b.rd_busy[i]}, {31'd0, e.busy_b[i]});
                end
                chk("a.write_conflict", 0, e.cyc, {31'd0, bus_a.write_conflict}, {31'd0, e.conf_a});
                chk("b.write_conflict", 0, e.cyc, {31'd0, bus_b.write_conflict}, {31'd0, e.conf_b});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached actual=running required=finished");
        $fatal(1);
    end

    initial begin : driver
        RESET = 1'b0;
        idle();
        apply();
        model_reset();
        repeat (3) @(negedge CLK);
        RESET = 1'b1;

        // Reset state with a few addresses
        idle(); s_rd_addr = '{5'd1, 5'd17, 5'd31}; step();

        // T1: write r5, then asynchronous reset between edges
        idle(); s_wr_en[0] = 1; s_wr_addr[0] = 5; s_wr_data[0] = 32'hDEADBEEF; s_rd_addr[0] = 5; step();
        idle(); s_rd_addr = '{5'd5, 5'd5, 5'd0}; step();
        idle(); s_rd_addr = '{5'd5, 5'd7, 5'd3}; do_reset();
        idle(); s_rd_addr[0] = 5; step();

        // T2: same-cycle bypass vs. old value
        idle(); s_wr_en[0] = 1; s_wr_addr[0] = 7; s_wr_data[0] = 32'h12345678; s_rd_addr[0] = 7; step();
        idle(); s_rd_addr[0] = 7; step();

        // T3: two ports, same address
        idle(); s_wr_en[0] = 1; s_wr_addr[0] = 3; s_wr_data[0] = 32'h1;
        s_wr_en[1] = 1; s_wr_addr[1] = 3; s_wr_data[1] = 32'h2; s_rd_addr[0] = 3; step();
        idle(); s_rd_addr[0] = 3; step();
        idle(); s_rd_addr[0] = 3; step();

        // T4: zero register
        idle(); s_wr_en[0] = 1; s_wr_addr[0] = 0; s_wr_data[0] = 32'hFFFFFFFF;
        s_wr_en[1] = 1; s_wr_addr[1] = 0; s_wr_data[1] = 32'hFFFFFFFF;
        s_issue_en = 1; s_issue_addr = 0; s_rd_addr[0] = 0; step();
        idle(); s_rd_addr[0] = 0; step();
        idle(); s_rd_addr[0] = 0; step();

        // T5: scoreboard issue / writeback
        idle(); s_issue_en = 1; s_issue_addr = 9; s_rd_addr[0] = 9; step();
        idle(); s_rd_addr[0] = 9; step();
        idle(); s_wr_en[0] = 1; s_wr_addr[0] = 9; s_wr_data[0] = 32'hCAFE0009; s_rd_addr[0] = 9; step();
        idle(); s_rd_addr[0] = 9; step();
        idle(); s_issue_en = 1; s_issue_addr = 9;
        s_wr_en[1] = 1; s_wr_addr[1] = 9; s_wr_data[1] = 32'h00000099; s_rd_addr[1] = 9; step();
        idle(); s_rd_addr[1] = 9; step();

        // T6: flush with concurrent issue and write
        idle(); s_issue_en = 1; s_issue_addr = 4; step();
        idle(); s_issue_en = 1; s_issue_addr = 6; s_rd_addr = '{5'd4, 5'd6, 5'd8}; step();
        idle(); s_flush = 1; s_issue_en = 1; s_issue_addr = 8;
        s_wr_en[0] = 1; s_wr_addr[0] = 6; s_wr_data[0] = 32'hA5A5A5A5; s_rd_addr = '{5'd4, 5'd6, 5'd9}; step();
        idle(); s_rd_addr = '{5'd4, 5'd6, 5'd8}; step();

        // Randomised traffic over a narrow address window to provoke collisions
        for (int n = 0; n < 1500; n++) begin
            idle();
            for (int i = 0; i < NR; i++)
                s_rd_addr[i] = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            for (int k = 0; k < NW; k++) begin
                s_wr_en[k]   = ($urandom_range(0, 2) != 0);
                s_wr_addr[k] = AW'($urandom_range(0, 7));
                s_wr_data[k] = $urandom;
            end
            s_issue_en   = $urandom_range(0, 1) == 1;
            s_issue_addr = AW'($urandom_range(0, 7));
            s_flush      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            else step();
        end

        idle();
        for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge CLK);
        @(posedge CLK);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
